// File: rtl/par2ser_tx_if.sv
// par2ser_tx bus: load-side and serial-side valid/ready handshakes.
// master = word producer / bit consumer (env), slave = transmitter.
interface par2ser_tx_if #(
  parameter int WIDTH = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             ser_valid;
  logic             ser_ready;
  logic             ser_bit;
  logic             ser_last;

  modport master (
    output load_valid, load_data, ser_ready,
    input  load_ready, ser_valid, ser_bit, ser_last
  );

  modport slave (
    input  load_valid, load_data, ser_ready,
    output load_ready, ser_valid, ser_bit, ser_last
  );
endinterface

// File: rtl/par2ser_tx.sv
// par2ser_tx: parallel-to-serial transmitter with a one-word holding buffer.
// Ports: clk, rst (sync, active-high), bus (par2ser_tx_if.slave), busy.
// Macro PAR2SER_MSB_FIRST_EN: MSB goes out first (default LSB first).
module par2ser_tx #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  par2ser_tx_if.slave   bus,
  output logic          busy
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             load_acc;
  logic             ser_acc;
  logic             last;
  logic             out_bit;
  logic [WIDTH-1:0] sh_next;

`ifdef PAR2SER_MSB_FIRST_EN
  assign out_bit = sh_q[WIDTH-1];
  assign sh_next = {sh_q[WIDTH-2:0], 1'b1};
`else
  assign out_bit = sh_q[0];
  assign sh_next = {1'b1, sh_q[WIDTH-1:1]};
`endif

  assign last     = (state_q == SHIFT) && (cnt_q == CW'(WIDTH-1));
  assign load_acc = bus.load_valid && bus.load_ready;
  assign ser_acc  = bus.ser_valid && bus.ser_ready;

  assign bus.load_ready = !hold_full_q;
  assign bus.ser_valid  = (state_q == SHIFT);
  assign bus.ser_last   = last;
  // Line idles high whenever no word is in flight.
  assign bus.ser_bit    = (state_q == SHIFT) ? out_bit : 1'b1;
  assign busy           = (state_q == SHIFT) || hold_full_q;

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (load_acc) begin
          sh_d    = bus.load_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (ser_acc && !last) begin
          sh_d  = sh_next;
          cnt_d = cnt_q + CW'(1);
        end else if (ser_acc && last) begin
          if (hold_full_q) begin
            sh_d        = hold_q;
            hold_full_d = 1'b0;
            cnt_d       = '0;
          end else if (load_acc) begin
            sh_d  = bus.load_data;
            cnt_d = '0;
          end else begin
            // Final shift leaves sh all ones for the idle line.
            sh_d    = sh_next;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        // A word arriving mid-word parks in the holding buffer.
        if (load_acc && !(ser_acc && last)) begin
          hold_d      = bus.load_data;
          hold_full_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sh_q        <= '1;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
    end
  end
endmodule

// File: tb/tb_par2ser_tx.sv
// tb_par2ser_tx: directed self-checking bench for par2ser_tx (WIDTH=8).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_par2ser_tx;
  localparam int W = 8;

  logic clk;
  logic rst;
  logic busy;
  int   n_cmp;
  int   n_bad;

  par2ser_tx_if #(.WIDTH(W)) bus ();

  par2ser_tx #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit i of the serial stream for word w.
  function automatic logic bit_of(input logic [W-1:0] w, input int i);
`ifdef PAR2SER_MSB_FIRST_EN
    return w[W-1-i];
`else
    return w[i];
`endif
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"}, 32'(bus.ser_valid), 0);
    chk({tag, ".bit"}, 32'(bus.ser_bit), 1);
    chk({tag, ".last"}, 32'(bus.ser_last), 0);
    chk({tag, ".lrdy"}, 32'(bus.load_ready), 1);
    chk({tag, ".busy"}, 32'(busy), 0);
  endtask

  // Check one bit on the line, then let the consumer take it.
  task automatic take_bit(input string tag, input logic [W-1:0] w,
                          input int i);
    chk($sformatf("%s.v%0d", tag, i), 32'(bus.ser_valid), 1);
    chk($sformatf("%s.b%0d", tag, i), 32'(bus.ser_bit), 32'(bit_of(w, i)));
    chk($sformatf("%s.l%0d", tag, i), 32'(bus.ser_last), 32'(i == W-1));
    tick();
  endtask

  task automatic load_word(input logic [W-1:0] w);
    bus.load_valid = 1'b1;
    bus.load_data  = w;
    tick();
    bus.load_valid = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.ser_ready  = 1'b1;

    // Reset then idle
    tick();
    chk_idle("rst1");
    tick();
    chk_idle("rst2");
    rst = 1'b0;
    tick();
    chk_idle("idle1");
    tick();
    chk_idle("idle2");

    // Single word A5
    load_word(8'hA5);
    chk("a5.busy", 32'(busy), 1);
    for (int i = 0; i < W; i++) take_bit("a5", 8'hA5, i);
    chk_idle("a5.end");

    // Back-to-back 0F then F0 via holding buffer
    load_word(8'h0F);
    chk("bb.v0", 32'(bus.ser_valid), 1);
    chk("bb.b0", 32'(bus.ser_bit), 32'(bit_of(8'h0F, 0)));
    bus.load_valid = 1'b1;
    bus.load_data  = 8'hF0;
    tick();
    bus.load_valid = 1'b0;
    chk("bb.lrdy_held", 32'(bus.load_ready), 0);
    chk("bb.busy", 32'(busy), 1);
    for (int i = 1; i < W; i++) begin
      if (i == W-1) chk("bb.lrdy_last", 32'(bus.load_ready), 0);
      take_bit("bb0F", 8'h0F, i);
    end
    chk("bb.lrdy_free", 32'(bus.load_ready), 1);
    for (int i = 0; i < W; i++) take_bit("bbF0", 8'hF0, i);
    chk_idle("bb.end");

    // Backpressure on 81
    load_word(8'h81);
    for (int i = 0; i < W; i++) begin
      chk($sformatf("bp.b%0d", i), 32'(bus.ser_bit), 32'(bit_of(8'h81, i)));
      bus.ser_ready = 1'b0;
      tick();
      tick();
      chk($sformatf("bp.sv%0d", i), 32'(bus.ser_valid), 1);
      chk($sformatf("bp.sb%0d", i), 32'(bus.ser_bit), 32'(bit_of(8'h81, i)));
      chk($sformatf("bp.sl%0d", i), 32'(bus.ser_last), 32'(i == W-1));
      bus.ser_ready = 1'b1;
      tick();
    end
    chk_idle("bp.end");

    // Same-cycle load on last bit, hold empty
    load_word(8'h01);
    for (int i = 0; i < W-1; i++) take_bit("sc01", 8'h01, i);
    chk("sc.last", 32'(bus.ser_last), 1);
    chk("sc.lrdy", 32'(bus.load_ready), 1);
    bus.load_valid = 1'b1;
    bus.load_data  = 8'h03;
    tick();
    bus.load_valid = 1'b0;
    chk("sc.busy", 32'(busy), 1);
    chk("sc.nohold", 32'(bus.load_ready), 1);
    for (int i = 0; i < W; i++) take_bit("sc03", 8'h03, i);
    chk_idle("sc.end");

    // Reset mid-word with a held word
    load_word(8'hFF);
    bus.load_valid = 1'b1;
    bus.load_data  = 8'h3C;
    tick();
    bus.load_valid = 1'b0;
    chk("mr.held", 32'(bus.load_ready), 0);
    tick();
    tick();
    chk("mr.cnt3", 32'(bus.ser_bit), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("mr.rst");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("mr.q%0d", i), 32'(bus.ser_valid), 0);
    end
    chk_idle("mr.end");

    // Reload after reset still works
    load_word(8'hA5);
    for (int i = 0; i < W; i++) take_bit("post", 8'hA5, i);
    chk_idle("post.end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/par2ser_tx.md
# par2ser_tx

Parallel-to-serial transmitter. It accepts WIDTH-bit words on a valid/ready load port and shifts them out one bit per accepted beat on a valid/ready serial port. It has a one-word holding buffer, so back-to-back words stream with no idle bubble. It sits in the common module library as the drain side of the enable-gated capture registers: captured words are unloaded bit-serially toward narrow links and debug taps.

## Interface
Parameters:
- WIDTH, 8, word width in bits; legal values are 2 to 32.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- load_valid  input  1  load_data holds a word.
- load_ready  output  1  a word can be accepted this cycle.
- load_data  input  WIDTH  word to transmit.
- ser_valid  output  1  ser_bit is valid.
- ser_ready  input  1  consumer takes ser_bit this cycle.
- ser_bit  output  1  current serial bit.
- ser_last  output  1  ser_bit is the final bit of the word.
- busy  output  1  a word is in the shift register or the holding buffer.

## Operation
- State: shift register sh[WIDTH-1:0], bit counter cnt of width clog2(WIDTH), holding register hold[WIDTH-1:0] with flag hold_full, and a two-state FSM (IDLE, SHIFT).
- Load handshake: a word is accepted when load_valid and load_ready are both high at a rising edge.
- load_ready = !hold_full. It is derived only from registered state, with no combinational path from load_valid or ser_ready.
- Serial handshake: a bit is accepted when ser_valid and ser_ready are both high. ser_valid is high exactly when the FSM is in SHIFT.
- IDLE with a load accepted: sh <= load_data, cnt <= 0, move to SHIFT. hold is untouched.
- SHIFT with a bit accepted and cnt != WIDTH-1: shift sh by one toward the output bit, cnt <= cnt+1.
- SHIFT with a bit accepted and cnt == WIDTH-1 (last bit):
  - if hold_full: sh <= hold, hold_full <= 0, cnt <= 0, stay in SHIFT.
  - else if a load is accepted this same cycle: sh <= load_data, cnt <= 0, stay in SHIFT.
  - else: move to IDLE.
- SHIFT with a load accepted and not in the last-bit reload case: hold <= load_data, hold_full <= 1.
- Last bit with hold full: load_ready is low that cycle, so no third word can be taken.
- ser_last = (state == SHIFT) && (cnt == WIDTH-1).
- busy = (state == SHIFT) || hold_full.
- ser_ready high while ser_valid is low has no effect. Stalls (ser_ready low) hold sh, cnt, ser_bit and ser_last stable.

## Timing
- Reset values: ser_valid=0, ser_last=0, ser_bit=1 (line idles high), load_ready=1, busy=0. FSM goes to IDLE, cnt=0, hold_full=0, and sh is set to all ones.
- rst overrides every other input in the same cycle. Reset in the middle of a word drops both the word in flight and the held word, and nothing is emitted afterwards.
- Latency: a load accepted in IDLE at edge N gives ser_valid=1 with the first bit after edge N.
- Throughput: one bit per cycle while ser_ready stays high. With the holding buffer or a same-cycle load, bit 0 of the next word follows the last bit of the previous word in the very next cycle.
- ser_bit in IDLE is 1.

## Configuration
- Macro: PAR2SER_MSB_FIRST_EN.
  - Defined: ser_bit = sh[WIDTH-1] and sh shifts left, so bit WIDTH-1 goes out first.
  - Undefined (default): ser_bit = sh[0] and sh shifts right, so bit 0 goes out first.
  - In both cases, bits shifted in are filled with 1.

## Test plan
- Reset then idle: hold rst for 2 cycles, then release -> ser_valid=0, ser_bit=1, load_ready=1 and busy=0 throughout.
- Single word, WIDTH=8, LSB-first, 8'hA5 loaded, ser_ready=1 -> bits 1,0,1,0,0,1,0,1 on consecutive cycles; ser_last high only on the 8th bit; ser_valid falls after it.
- Back-to-back: load 8'h0F, then load 8'hF0 one cycle later -> load_ready drops while hold_full; 16 contiguous bits with no gap; ser_last pulses on bits 8 and 16.
- Backpressure: 8'h81 with ser_ready toggling 1,0,0,1,... -> ser_bit and ser_last stay stable across stalls; the bit sequence is unchanged.
- Same-cycle load on last bit with hold empty: 8'h01 then 8'h03 presented exactly on the last-bit handshake -> no bubble; busy stays 1.
- Reset mid-word: assert rst after 3 bits of 8'hFF with a second word held -> next cycle ser_valid=0, busy=0, load_ready=1; no remaining bits are emitted. Repeat with PAR2SER_MSB_FIRST_EN defined: 8'hA5 -> bits 1,0,1,0,0,1,0,1 in MSB-first order.
